// File: rtl/box_plotter.sv
// Box plotter: queues box requests and rasterises each one into BOX_W x BOX_H
// pixel writes for a 160x120 VGA adapter, clipping pixels that fall off-screen.
module box_plotter #(
    parameter int unsigned BOX_W = 5,
    parameter int unsigned BOX_H = 3,
    parameter int unsigned DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       overflow
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int unsigned DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [DXW-1:0] DX_LAST  = DXW'(BOX_W - 1);
    localparam logic [DYW-1:0] DY_LAST  = DYW'(BOX_H - 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {StIdle, StDraw} state_t;

    logic [17:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic           full, empty, push, pop;
    logic [17:0]    head;

    state_t         state_q, state_d;
    logic [7:0]     base_x_q, base_x_d;
    logic [6:0]     base_y_q, base_y_d;
    logic [2:0]     base_c_q, base_c_d;
    logic [DXW-1:0] dx_q, dx_d;
    logic [DYW-1:0] dy_q, dy_d;
    logic [7:0]     x_d;
    logic [6:0]     y_d;
    logic [2:0]     colour_d;
    logic           plot_d;
    logic [8:0]     sum_x;
    logic [7:0]     sum_y;
    logic           clip;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // A push against a full FIFO is dropped even when a pop frees a slot this cycle.
    assign push  = in_valid && !full;
    assign pop   = (state_q == StIdle) && !empty;
    assign head  = mem[rd_ptr_q];
    assign busy  = (state_q == StDraw) || !empty;

    assign sum_x = {1'b0, base_x_q} + 9'(dx_q);
    assign sum_y = {1'b0, base_y_q} + 8'(dy_q);
    assign clip  = (sum_x >= 9'd160) || (sum_y >= 8'd120);

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr_q] <= {in_x, in_y, in_colour};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
            if (in_valid && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            base_x_q <= '0;
            base_y_q <= '0;
            base_c_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            base_c_q <= base_c_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            x        <= x_d;
            y        <= y_d;
            colour   <= colour_d;
            plot     <= plot_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        base_c_d = base_c_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        x_d      = x;
        y_d      = y;
        colour_d = colour;
        plot_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StDraw;
                    {base_x_d, base_y_d, base_c_d} = head;
                    dx_d = '0;
                    dy_d = '0;
                end
            end
            StDraw: begin
                // Clipped pixels still consume their cycle so box timing is fixed.
                if (!clip) begin
                    plot_d   = 1'b1;
                    x_d      = sum_x[7:0];
                    y_d      = sum_y[6:0];
                    colour_d = base_c_q;
                end
                if (dx_q == DX_LAST) begin
                    dx_d = '0;
                    if (dy_q == DY_LAST) begin
                        dy_d    = '0;
                        state_d = StIdle;
                    end else begin
                        dy_d = dy_q + DYW'(1);
                    end
                end else begin
                    dx_d = dx_q + DXW'(1);
                end
            end
        endcase
    end
endmodule

// File: tb/tb_box_plotter.sv
// Bench for box_plotter: a queueing model predicts accepted boxes and the
// timed pixel stream, which is compared with every plot pulse seen.
module tb_box_plotter;
    localparam int BOX_W = 5;
    localparam int BOX_H = 3;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_x = '0;
    logic [6:0] in_y = '0;
    logic [2:0] in_colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, overflow;

    box_plotter #(.BOX_W(BOX_W), .BOX_H(BOX_H), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_colour(in_colour), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int e = 0;             // index of the next rising edge
    // Model: pending requests, earliest edge the drawer can take another, drops.
    logic [17:0] mq[$];
    int          next_pop_ok = 0;
    int          last_pop = 0;
    logic        ovf_exp = 1'b0;
    logic [7:0]  mx = '0;
    logic [6:0]  my = '0;
    logic [2:0]  mc = '0;
    // Pixel records: {edge, x, y, colour}
    logic [49:0] exp_q[$];
    logic [49:0] obs_q[$];

    task automatic expand(input logic [17:0] r, input int p);
        int bx = int'(r[17:10]);
        int by = int'(r[9:3]);
        for (int dy = 0; dy < BOX_H; dy++) begin
            for (int dx = 0; dx < BOX_W; dx++) begin
                if (bx + dx < 160 && by + dy < 120) begin
                    exp_q.push_back({32'(p + 1 + dy * BOX_W + dx), 8'(bx + dx), 7'(by + dy),
                                     r[2:0]});
                    mx = 8'(bx + dx);
                    my = 7'(by + dy);
                    mc = r[2:0];
                end
            end
        end
    endtask

    task automatic model_edge(input logic v, input logic [17:0] r);
        bit was_full = (mq.size() == DEPTH);
        if (e >= next_pop_ok && mq.size() > 0) begin
            expand(mq.pop_front(), e);
            last_pop = e;
            next_pop_ok = e + BOX_W * BOX_H + 1;
        end
        if (v) begin
            if (was_full) ovf_exp = 1'b1;
            else mq.push_back(r);
        end
    endtask

    task automatic model_reset();
        logic [49:0] keep[$];
        foreach (exp_q[i]) if (int'(exp_q[i][49:18]) < e) keep.push_back(exp_q[i]);
        exp_q = keep;
        mq.delete();
        next_pop_ok = 0;
        ovf_exp = 1'b0;
        mx = '0;
        my = '0;
        mc = '0;
    endtask

    task automatic step(input logic v, input logic [7:0] ix, input logic [6:0] iy,
                        input logic [2:0] ic, input logic rst);
        reset = rst;
        in_valid = v;
        in_x = ix;
        in_y = iy;
        in_colour = ic;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(v, {ix, iy, ic});
        #1;
        if (plot === 1'b1) obs_q.push_back({32'(e), x, y, colour});
        e++;
    endtask

    task automatic drain(output int low);
        low = -1;
        for (int i = 0; i < 3000; i++) begin
            if (busy === 1'b0) begin
                low = e - 1;
                break;
            end
            step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 8'd12, 7'd12, 3'd5, 1'b1);
        step(1'b1, 8'd13, 7'd13, 3'd6, 1'b1);
        checks++; if (x !== 8'd0) begin failures++; $display("FAIL reset_x: got %0d want 0", x); end
        checks++; if (y !== 7'd0) begin failures++; $display("FAIL reset_y: got %0d want 0", y); end
        checks++;
        if (colour !== 3'd0) begin failures++; $display("FAIL reset_colour: got %0d want 0", colour); end
        checks++; if (plot !== 1'b0) begin failures++; $display("FAIL reset_plot: got %b want 0", plot); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            failures++; $display("FAIL reset_ignores_valid: got busy=%b plot=%b want 0 0", busy, plot);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single();
        int low;
        string nm = "single";
        obs_q.delete(); exp_q.delete();
        step(1'b1, 8'd38, 7'd4, 3'b100, 1'b0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_push: got %b want 1", busy); end
        step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        checks++;
        if (plot !== 1'b0) begin failures++; $display("FAIL single_plot_pop: got %b want 0", plot); end
        drain(low);
        checks++;
        if (low != last_pop + 15) begin
            failures++; $display("FAIL %s_end: got %0d want %0d", nm, low, last_pop + 15);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_npix: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL %s_pix%0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({x, y, colour} !== {mx, my, mc}) begin
            failures++; $display("FAIL %s_hold: got %h want %h", nm, {x, y, colour}, {mx, my, mc});
        end
    endtask

    task automatic test_push_pop_same_cycle();
        int low;
        string nm = "pushpop";
        obs_q.delete(); exp_q.delete();
        step(1'b1, 8'd70, 7'd50, 3'd3, 1'b0);
        step(1'b1, 8'd90, 7'd60, 3'd6, 1'b0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL pushpop_busy: got %b want 1", busy); end
        drain(low);
        checks++;
        if (low != last_pop + 15) begin
            failures++; $display("FAIL %s_end: got %0d want %0d", nm, low, last_pop + 15);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_npix: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL %s_pix%0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int low;
        string nm = "b2b";
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 33; i++) begin
            step(1'b1, (i % 2 == 1) ? 8'd43 : 8'd38, 7'(4 + 3 * i), 3'(i), 1'b0);
        end
        drain(low);
        checks++;
        if (low != last_pop + 15) begin
            failures++; $display("FAIL %s_end: got %0d want %0d", nm, low, last_pop + 15);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_npix: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL %s_pix%0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overflow !== ovf_exp) begin
            failures++; $display("FAIL %s_ovf: got %b want %b", nm, overflow, ovf_exp);
        end
    endtask

    task automatic test_clip();
        int low;
        string nm = "clip";
        obs_q.delete(); exp_q.delete();
        step(1'b1, 8'd158, 7'd118, 3'b010, 1'b0);
        drain(low);
        checks++;
        if (low != last_pop + 15) begin
            failures++; $display("FAIL %s_end: got %0d want %0d", nm, low, last_pop + 15);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_npix: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL %s_pix%0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({x, y, colour} !== {mx, my, mc}) begin
            failures++; $display("FAIL %s_hold: got %h want %h", nm, {x, y, colour}, {mx, my, mc});
        end
    endtask

    task automatic test_random();
        int low;
        string nm = "random";
        logic v;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 60; i++) begin
            v = (i == 59) ? 1'b1 : 1'($urandom_range(0, 1));
            step(v, 8'($urandom), 7'($urandom), 3'($urandom), 1'b0);
        end
        drain(low);
        checks++;
        if (low != last_pop + 15) begin
            failures++; $display("FAIL %s_end: got %0d want %0d", nm, low, last_pop + 15);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_npix: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL %s_pix%0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({x, y, colour} !== {mx, my, mc}) begin
            failures++; $display("FAIL %s_hold: got %h want %h", nm, {x, y, colour}, {mx, my, mc});
        end
        checks++;
        if (overflow !== ovf_exp) begin
            failures++; $display("FAIL %s_ovf: got %b want %b", nm, overflow, ovf_exp);
        end
    endtask

    task automatic test_overflow();
        int low;
        string nm = "overflow";
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'($urandom_range(0, 150)), 7'(i), 3'($urandom), 1'b0);
        end
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set: got %b want 1", overflow); end
        drain(low);
        checks++;
        if (low != last_pop + 15) begin
            failures++; $display("FAIL %s_end: got %0d want %0d", nm, low, last_pop + 15);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_npix: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL %s_pix%0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overflow !== ovf_exp) begin
            failures++; $display("FAIL %s_sticky: got %b want %b", nm, overflow, ovf_exp);
        end
    endtask

    task automatic test_reset_mid_box();
        int e0;
        string nm = "midreset";
        obs_q.delete(); exp_q.delete();
        e0 = e;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(10 + 10 * i), 7'(10 + 10 * i), 3'(i + 1), 1'b0);
        while (e <= e0 + 8) step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        checks++;
        if (plot !== 1'b1) begin failures++; $display("FAIL midreset_pix7: got %b want 1", plot); end
        step(1'b1, 8'd5, 7'd5, 3'd7, 1'b1);
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_after: got plot=%b busy=%b want 0 0", plot, busy);
        end
        checks++;
        if ({x, y, colour} !== {mx, my, mc}) begin
            failures++; $display("FAIL %s_xyc: got %h want %h", nm, {x, y, colour}, {mx, my, mc});
        end
        for (int i = 0; i < 40; i++) step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("FAIL midreset_idle: got busy=%b ovf=%b want 0 0", busy, overflow);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_npix: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL %s_pix%0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_push_pop_same_cycle();
        test_back_to_back();
        test_clip();
        test_random();
        test_overflow();
        test_reset_mid_box();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
